// File: rtl/adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int MAX_WIDTH     = 64;

    // {cout, sum} sized for the widest legal adder; narrower users take the low WIDTH+1 bits.
    typedef logic [MAX_WIDTH:0] result_t;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder: one cell of the ripple-carry chain, purely combinational.
module fa_cell (
    output logic co,
    output logic s,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin, one cycle after in_valid.
// Accepts an operand set every cycle; outputs hold between results and clear on reset.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             out_valid
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("adder: WIDTH out of range 1..64");
    end

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic             r_cout;
    logic [WIDTH-1:0] r_sum;
    logic             r_out_valid;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_fa (
            .co (w_carry[i+1]),
            .s  (w_sum[i]),
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_carry[i])
        );
    end

    // Result registers only load on accepted inputs, so idle-cycle operands never reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cout      <= 1'b0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_cout <= w_carry[WIDTH];
                r_sum  <= w_sum;
            end
        end
    end

    assign cout      = r_cout;
    assign sum       = r_sum;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adder.sv
// Directed and random checks of adder at WIDTH 1, 8 and 32 against an a+b+cin scoreboard.
module tb_adder;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a1, b1, c1, v1, cout1, sum1, ov1;
    logic [7:0]  a8, b8, sum8;
    logic        c8, v8, cout8, ov8;
    logic [31:0] a32, b32, sum32;
    logic        c32, v32, cout32, ov32;

    adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .cout(cout1), .sum(sum1), .a(a1), .b(b1),
        .cin(c1), .in_valid(v1), .out_valid(ov1)
    );
    adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .cout(cout8), .sum(sum8), .a(a8), .b(b8),
        .cin(c8), .in_valid(v8), .out_valid(ov8)
    );
    adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .cout(cout32), .sum(sum32), .a(a32), .b(b32),
        .cin(c32), .in_valid(v32), .out_valid(ov32)
    );

    int total = 0;
    int bad   = 0;

    result_t q1[$], q8[$], q32[$];
    result_t h1, h8, h32;

    task automatic chk(input string tag, input result_t obs, input result_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_w1"},  result_t'({ov1,  cout1,  sum1}),  '0);
        chk({tag, "_w8"},  result_t'({ov8,  cout8,  sum8}),  '0);
        chk({tag, "_w32"}, result_t'({ov32, cout32, sum32}), '0);
    endtask

    // Push expectations for this edge, clock once, then compare valid flags and result/hold values.
    task automatic tick();
        logic e1, e8, e32;
        e1 = v1; e8 = v8; e32 = v32;
        if (v1)  q1.push_back(result_t'({1'b0, a1}) + result_t'(b1) + result_t'(c1));
        if (v8)  q8.push_back(result_t'({1'b0, a8}) + result_t'(b8) + result_t'(c8));
        if (v32) q32.push_back(result_t'({1'b0, a32}) + result_t'(b32) + result_t'(c32));
        @(posedge clk);
        #1;
        chk("w1_vld",  result_t'(ov1),  result_t'(e1));
        chk("w8_vld",  result_t'(ov8),  result_t'(e8));
        chk("w32_vld", result_t'(ov32), result_t'(e32));
        if (e1  && q1.size()  > 0) h1  = q1.pop_front();
        if (e8  && q8.size()  > 0) h8  = q8.pop_front();
        if (e32 && q32.size() > 0) h32 = q32.pop_front();
        chk("w1_res",  result_t'({cout1,  sum1}),  h1);
        chk("w8_res",  result_t'({cout8,  sum8}),  h8);
        chk("w32_res", result_t'({cout32, sum32}), h32);
    endtask

    task automatic idle_all();
        v1 = 1'b0; v8 = 1'b0; v32 = 1'b0;
    endtask

    initial begin
        h1 = '0; h8 = '0; h32 = '0;
        a1 = 0; b1 = 0; c1 = 0; v1 = 1;
        a8 = 8'h12; b8 = 8'h34; c8 = 0; v8 = 1;
        a32 = 32'h1; b32 = 32'h2; c32 = 0; v32 = 1;

        // Reset holds outputs at zero before and across the first edge despite valid inputs.
        #2;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_edge");
        rst = 1'b0;

        // First edge after release is processed; exhaustive WIDTH=1 combinations in order.
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            v1 = 1'b1;
            a8 = 8'(i * 37); b8 = 8'(i * 91); c8 = 1'(i);
            a32 = 32'(i) << 28; b32 = 32'hF000_0000; c32 = 1'(i >> 1);
            v8 = 1'b1; v32 = 1'b1;
            tick();
        end

        // Carry propagation and all-ones wrap-around.
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; c32 = 1'b0;
        tick();
        chk("w8_ff01", result_t'({cout8, sum8}), result_t'(9'h100));
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; c32 = 1'b1;
        tick();
        chk("w8_ffff1",  result_t'({cout8, sum8}),   result_t'(9'h1FF));
        chk("w32_ffff1", result_t'({cout32, sum32}), result_t'(33'h1_FFFF_FFFF));

        // Back-to-back inputs on four consecutive edges.
        for (int i = 0; i < 4; i++) begin
            a1 = 1'(i); b1 = 1'(i >> 1); c1 = 1'b1;
            a8 = 8'(8'hF0 + i); b8 = 8'(8'h10 * i); c8 = 1'(i);
            a32 = $urandom; b32 = $urandom; c32 = 1'(i);
            tick();
        end

        // Idle cycles with changing operands: outputs hold, out_valid low.
        idle_all();
        for (int i = 0; i < 3; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            a8 = 'x; b8 = 'x; c8 = 1'bx;
            a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
            tick();
        end

        // Produce a result, then hit reset mid-cycle with another result pending.
        v1 = 1; v8 = 1; v32 = 1;
        a1 = 1; b1 = 1; c1 = 0;
        a8 = 8'h55; b8 = 8'hAA; c8 = 1;
        a32 = 32'h8000_0000; b32 = 32'h8000_0000; c32 = 1;
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(posedge clk);
        #1;
        chk_zero("rst_pending");
        q1.delete(); q8.delete(); q32.delete();
        h1 = '0; h8 = '0; h32 = '0;
        idle_all();
        rst = 1'b0;
        tick();
        tick();

        // Random vectors with occasional idle cycles.
        for (int n = 0; n < 1200; n++) begin
            v1  = ($urandom_range(15) != 0);
            v8  = ($urandom_range(15) != 0);
            v32 = ($urandom_range(15) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
            tick();
        end

        idle_all();
        tick();
        chk("sb_empty", result_t'(q1.size() + q8.size() + q32.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 1: operand and sum width in bits, legal range 1..64.
REQ-002 Port order is fixed, and positional instantiation is legal: clk, rst, cout, sum, a, b, cin, in_valid, out_valid.
REQ-003 clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  reset; asynchronous assert, active-high.
REQ-005 cout  output  1  registered carry-out of a + b + cin.
REQ-006 sum  output  WIDTH  registered low WIDTH bits of a + b + cin.
REQ-007 a  input  WIDTH  addend A, unsigned.
REQ-008 b  input  WIDTH  addend B, unsigned.
REQ-009 cin  input  1  carry-in.
REQ-010 in_valid  input  1  a, b and cin are sampled on this rising edge when in_valid=1.
REQ-011 out_valid  output  1  cout and sum hold a fresh result.

Function
REQ-012 {cout, sum} SHALL equal the (WIDTH+1)-bit unsigned value a + b + cin.
- No truncation.
- cout is the carry out of bit WIDTH-1.
REQ-013 Latency SHALL be exactly 1 cycle: inputs sampled on edge N with in_valid=1 appear on cout/sum with out_valid=1 after edge N.
REQ-014 out_valid SHALL be in_valid registered: it is high for exactly one cycle per accepted input.
REQ-015 With in_valid=0 on an edge, cout and sum SHALL hold their previous values and out_valid SHALL be 0.
REQ-016 The adder SHALL accept a new operand set every cycle: no backpressure, no stall, full throughput.
REQ-017 Wrap-around: all-ones a + all-ones b + cin=1 SHALL give sum = all-ones and cout=1.
REQ-018 X/Z on a, b or cin while in_valid=0 SHALL NOT affect the outputs.
REQ-019 The combinational path SHALL be a ripple-carry chain of WIDTH 1-bit full-adder cells.
- Per cell: s = a^b^c; co = (a&b)|(a&c)|(b&c).

Reset
REQ-020 While rst=1, cout, sum and out_valid SHALL be 0, asynchronously and regardless of clk.
REQ-021 On rst deassertion, the first edge with in_valid=1 SHALL be processed normally.
- There are no dead cycles beyond that edge.
REQ-022 If rst asserts while a result is pending or held, the result SHALL be discarded.
- out_valid SHALL NOT pulse for that result after reset releases.

Structure
REQ-023 A shared package adder_pkg SHALL hold:
- the WIDTH default constant;
- the maximum-width constant (64);
- a result typedef for the {cout, sum} (WIDTH+1)-bit value.
REQ-024 One sub-module fa_cell (ports: co, s, a, b, ci; purely combinational) SHALL be instantiated WIDTH times via generate.
REQ-025 All registers SHALL live in adder; fa_cell SHALL contain no state.

Verification
REQ-026 WIDTH=1, all 8 input combinations, each with in_valid=1, in order (a,b,cin) = 000, 001, 010, 011, 100, 101, 110, 111. One cycle later, (sum,cout) SHALL be:
- 000 -> 0,0
- 001 -> 1,0
- 010 -> 1,0
- 011 -> 0,1
- 100 -> 1,0
- 101 -> 0,1
- 110 -> 0,1
- 111 -> 1,1
REQ-027 WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, out_valid=1 one cycle later. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-028 Back-to-back inputs for 4 consecutive cycles -> 4 consecutive out_valid pulses with matching results, each delayed one cycle.
REQ-029 in_valid=0 with random a/b -> outputs unchanged from the previous result; out_valid=0.
REQ-030 rst=1 asserted mid-cycle, asynchronous to clk, after a result is produced -> cout=0, sum=0, out_valid=0 immediately. After release, no stale out_valid pulse.
REQ-031 Random self-check: at least 1000 random vectors at WIDTH=1, 8 and 32, compared against the a+b+cin reference model.
